// File: rtl/pic_axi_lite_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pic_axi_lite_pkg: register map, response codes and FSM states of the PIC |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package pic_axi_lite_pkg;

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_ENABLE  = 8'h04;
  localparam logic [7:0] OFF_MODE    = 8'h08;
  localparam logic [7:0] OFF_PENDING = 8'h0C;
  localparam logic [7:0] OFF_ACTIVE  = 8'h10;
  localparam logic [7:0] OFF_VECTOR  = 8'h14;
  localparam logic [7:0] OFF_ID      = 8'h18;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] PIC_ID_DEFAULT = 32'h5049_4301;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  function automatic logic addr_mapped(input logic [7:0] addr);
    return (addr == OFF_CTRL)    || (addr == OFF_ENABLE) || (addr == OFF_MODE) ||
           (addr == OFF_PENDING) || (addr == OFF_ACTIVE) || (addr == OFF_VECTOR) ||
           (addr == OFF_ID);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pic_axi_lite_slave_priority_enc.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pic_priority_enc: lowest-index active line wins                         |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module pic_priority_enc #(
  parameter int unsigned NUM_IRQ = 16
) (
  input  logic [NUM_IRQ-1:0] active,
  output logic               valid,
  output logic [4:0]         index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        valid = 1'b1;
        index = 5'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pic_axi_lite_slave.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pic_axi_lite_slave: AXI4-Lite CSR responder of the interrupt controller |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module pic_axi_lite_slave
  import pic_axi_lite_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 16,
  parameter logic [31:0] PIC_ID  = PIC_ID_DEFAULT
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [31:0]        s_axi_lite_awaddr,
  input  logic               s_axi_lite_awvalid,
  output logic               s_axi_lite_awready,
  input  logic [31:0]        s_axi_lite_wdata,
  input  logic               s_axi_lite_wvalid,
  output logic               s_axi_lite_wready,
  output logic [1:0]         s_axi_lite_bresp,
  output logic               s_axi_lite_bvalid,
  input  logic               s_axi_lite_bready,
  input  logic [31:0]        s_axi_lite_araddr,
  input  logic               s_axi_lite_arvalid,
  output logic               s_axi_lite_arready,
  output logic [31:0]        s_axi_lite_rdata,
  output logic [1:0]         s_axi_lite_rresp,
  output logic               s_axi_lite_rvalid,
  input  logic               s_axi_lite_rready,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               interrupt
);

  wr_state_e          wr_state_q, wr_state_d;
  rd_state_e          rd_state_q, rd_state_d;
  logic               aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic               awready_q, awready_d, wready_q, wready_d;
  logic [7:0]         awaddr_q, awaddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               bvalid_q, bvalid_d, wr_upd_q, wr_upd_d;
  logic [1:0]         bresp_q, bresp_d, rresp_q, rresp_d;
  logic               arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ctrl_q, ctrl_d, interrupt_q, interrupt_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d, mode_q, mode_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d, irq_dly_q, irq_dly_d;
  logic [NUM_IRQ-1:0] w1c, active;
  logic               aw_hs, w_hs, vec_valid, rd_hit;
  logic [4:0]         vec_index;
  logic [31:0]        rd_word;
  logic               unused_bits;

  assign aw_hs  = s_axi_lite_awvalid & awready_q;
  assign w_hs   = s_axi_lite_wvalid & wready_q;
  assign active = pending_q & enable_q;
  assign unused_bits = ^{s_axi_lite_awaddr[31:8], s_axi_lite_araddr[31:8], wdata_q};

  pic_priority_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .active (active),
    .valid  (vec_valid),
    .index  (vec_index)
  );

  // AW and W are captured independently; the register write fires one cycle later, alongside bvalid.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_upd_d   = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awaddr_d = s_axi_lite_awaddr[7:0];
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = s_axi_lite_wdata;
        end
        if (aw_got_d && w_got_d) begin
          wr_state_d = W_RESP;
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = addr_mapped(awaddr_d) ? RESP_OKAY : RESP_SLVERR;
          wr_upd_d   = 1'b1;
        end
      end
      W_RESP: begin
        if (s_axi_lite_bready) begin
          wr_state_d = W_IDLE;
          bvalid_d   = 1'b0;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    awready_d = (wr_state_d == W_IDLE) & ~aw_got_d;
    wready_d  = (wr_state_d == W_IDLE) & ~w_got_d;
  end

  always_comb begin
    rd_word = '0;
    rd_hit  = 1'b1;
    case (s_axi_lite_araddr[7:0])
      OFF_CTRL:    rd_word[0] = ctrl_q;
      OFF_ENABLE:  rd_word[NUM_IRQ-1:0] = enable_q;
      OFF_MODE:    rd_word[NUM_IRQ-1:0] = mode_q;
      OFF_PENDING: rd_word[NUM_IRQ-1:0] = pending_q;
      OFF_ACTIVE:  rd_word[NUM_IRQ-1:0] = active;
      OFF_VECTOR:  rd_word = {vec_valid, 26'b0, vec_index};
      OFF_ID:      rd_word = PIC_ID;
      default:     rd_hit = 1'b0;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rvalid_d   = rvalid_q;
    case (rd_state_q)
      R_IDLE: begin
        if (s_axi_lite_arvalid && arready_q) begin
          rd_state_d = R_DATA;
          rdata_d    = rd_word;
          rresp_d    = rd_hit ? RESP_OKAY : RESP_SLVERR;
          rvalid_d   = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi_lite_rready) begin
          rd_state_d = R_IDLE;
          rvalid_d   = 1'b0;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    arready_d = (rd_state_d == R_IDLE);
  end

  // Edge lines: a fresh edge beats a same-cycle W1C. Level lines simply follow irq.
  always_comb begin
    ctrl_d   = ctrl_q;
    enable_d = enable_q;
    mode_d   = mode_q;
    w1c      = '0;
    if (wr_upd_q) begin
      case (awaddr_q)
        OFF_CTRL:    ctrl_d   = wdata_q[0];
        OFF_ENABLE:  enable_d = wdata_q[NUM_IRQ-1:0];
        OFF_MODE:    mode_d   = wdata_q[NUM_IRQ-1:0];
        OFF_PENDING: w1c      = wdata_q[NUM_IRQ-1:0];
        default:     ;
      endcase
    end
    pending_d   = (mode_q & ((irq & ~irq_dly_q) | (pending_q & ~w1c))) | (~mode_q & irq);
    irq_dly_d   = irq;
    interrupt_d = ctrl_q & (|active);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q  <= W_IDLE;
      rd_state_q  <= R_IDLE;
      aw_got_q    <= 1'b0;
      w_got_q     <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
      wr_upd_q    <= 1'b0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      ctrl_q      <= 1'b0;
      enable_q    <= '0;
      mode_q      <= '0;
      pending_q   <= '0;
      irq_dly_q   <= '0;
      interrupt_q <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      aw_got_q    <= aw_got_d;
      w_got_q     <= w_got_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      wr_upd_q    <= wr_upd_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      ctrl_q      <= ctrl_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      pending_q   <= pending_d;
      irq_dly_q   <= irq_dly_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign s_axi_lite_awready = awready_q;
  assign s_axi_lite_wready  = wready_q;
  assign s_axi_lite_bvalid  = bvalid_q;
  assign s_axi_lite_bresp   = bresp_q;
  assign s_axi_lite_arready = arready_q;
  assign s_axi_lite_rvalid  = rvalid_q;
  assign s_axi_lite_rdata   = rdata_q;
  assign s_axi_lite_rresp   = rresp_q;
  assign interrupt          = interrupt_q;

endmodule
`default_nettype wire
